fb_arbiter: RTL

- Owns the single-port 8x8 two-colour frame-buffer RAM (64 x 2 bit, synchronous read) behind led_driver.
- Shares the RAM between three users:
  - the matrix scan reader (display refresh);
  - the light-pen writer (pixel paint);
  - an internal clear sequencer started by the debounced clean button.
- Arbitration is fixed-priority with a starvation guard for pen writes.

---
 rtl/fb_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/fb_arbiter.sv
// +--------------------------------------------------------------------------+
// | fb_arbiter : frame-buffer RAM owner; scan / pen / clear arbitration      |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module fb_arbiter #(
  parameter int                ADDR_W   = 6,
  parameter int                DATA_W   = 2,
  parameter logic [DATA_W-1:0] CLR_VAL  = 2'b00,
  parameter int                MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scan_req,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic              scan_gnt,
  output logic              scan_valid,
  output logic [DATA_W-1:0] scan_data,
  input  logic              pen_req,
  input  logic [ADDR_W-1:0] pen_addr,
  input  logic [DATA_W-1:0] pen_data,
  output logic              pen_gnt,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                scan_gnt_q, scan_gnt_d;
  logic                pen_gnt_q, pen_gnt_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic                clr_busy_q, clr_busy_d;
  logic                clr_done_q, clr_done_d;
  logic                clr1_q, clr1_d;
  logic                rd2_q, clr2_q;
  logic                scan_valid_q;
  logic [DATA_W-1:0]   scan_data_q;

  // A requester is blind to its own grant for one cycle, so its stale req is ignored then.
  logic scan_live, pen_live;
  assign scan_live = scan_req & ~scan_gnt_q;
  assign pen_live  = pen_req  & ~pen_gnt_q;

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    scan_gnt_d  = 1'b0;
    pen_gnt_d   = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    clr_busy_d  = 1'b0;
    clr_done_d  = 1'b0;
    clr1_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        clr_done_d = clr_busy_q;
        if (clr_start) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
          if (pen_live && (wait_cnt_q != WAIT_MAX)) wait_cnt_d = wait_cnt_q + 1'b1;
        end else if (pen_live && (wait_cnt_q == WAIT_MAX)) begin
          pen_gnt_d   = 1'b1;
          ram_we_d    = 1'b1;
          ram_addr_d  = pen_addr;
          ram_wdata_d = pen_data;
          wait_cnt_d  = '0;
        end else if (scan_live) begin
          scan_gnt_d = 1'b1;
          ram_addr_d = scan_addr;
          if (pen_live && (wait_cnt_q != WAIT_MAX)) wait_cnt_d = wait_cnt_q + 1'b1;
        end else if (pen_live) begin
          pen_gnt_d   = 1'b1;
          ram_we_d    = 1'b1;
          ram_addr_d  = pen_addr;
          ram_wdata_d = pen_data;
          wait_cnt_d  = '0;
        end
      end

      ST_CLEAR: begin
        ram_we_d    = 1'b1;
        ram_addr_d  = clr_cnt_q;
        ram_wdata_d = CLR_VAL;
        clr_busy_d  = 1'b1;
        clr_cnt_d   = clr_cnt_q + 1'b1;
        if (&clr_cnt_q) state_d = ST_IDLE;
        // Scan is served from CLR_VAL so the display never stalls behind the clear.
        if (scan_live) begin
          scan_gnt_d = 1'b1;
          clr1_d     = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      clr_cnt_q    <= '0;
      wait_cnt_q   <= '0;
      scan_gnt_q   <= 1'b0;
      pen_gnt_q    <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      clr_busy_q   <= 1'b0;
      clr_done_q   <= 1'b0;
      clr1_q       <= 1'b0;
      rd2_q        <= 1'b0;
      clr2_q       <= 1'b0;
      scan_valid_q <= 1'b0;
      scan_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      scan_gnt_q   <= scan_gnt_d;
      pen_gnt_q    <= pen_gnt_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      clr_busy_q   <= clr_busy_d;
      clr_done_q   <= clr_done_d;
      clr1_q       <= clr1_d;
      rd2_q        <= scan_gnt_q;
      clr2_q       <= clr1_q;
      scan_valid_q <= rd2_q;
      if (rd2_q) scan_data_q <= clr2_q ? CLR_VAL : ram_rdata;
    end
  end

  assign scan_gnt   = scan_gnt_q;
  assign scan_valid = scan_valid_q;
  assign scan_data  = scan_data_q;
  assign pen_gnt    = pen_gnt_q;
  assign clr_busy   = clr_busy_q;
  assign clr_done   = clr_done_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;

endmodule

`default_nettype wire
